dtw_traceback: RTL and testbench
================================

DTW_TRACEBACK -- requirements
Module: dtw_traceback

Interface
REQ-001 SHALL have clk (input, 1): system clock; all state changes on rising edge.
REQ-002 SHALL have nrst (input, 1): reset, asynchronous, active-low.
REQ-003 SHALL have start (input, 1): one-cycle request to begin a walk; ignored unless idle.
REQ-004 SHALL have len_t (input, 5) and len_r (input, 5): last T index and last R index; sampled when start is accepted.
REQ-005 SHALL have mem_rd_en (output, 1), mem_raddr (output, 10, {i,j}) and mem_rdata (input, 2): path-code RAM read port, valid one cycle after mem_rd_en.
REQ-006 SHALL have out_valid (output, 1), out_ready (input, 1), out_i (output, 5), out_j (output, 5) and out_last (output, 1): warping-path beat stream.
REQ-007 SHALL have busy (output, 1), done (output, 1) and error (output, 1).

Function
REQ-008 SHALL use path codes 11 = from (i-1,j-1), 10 = from (i-1,j), 01 = from (i,j-1) and 00 = invalid.
REQ-009 SHALL implement states IDLE, EMIT, READ, WAIT, DONE and ERR; busy = (state != IDLE).
REQ-010 IDLE: start=1 SHALL latch (i,j)=(len_t,len_r) and go to EMIT; first out_valid in the next cycle.
REQ-011 EMIT SHALL drive out_valid=1 with out_i=i and out_j=j, holding all three stable until out_valid&out_ready.
REQ-012 out_last SHALL be 1 only while (i,j)=(0,0) in EMIT.
REQ-013 On EMIT handshake at (0,0), the block SHALL go to DONE.
REQ-014 On EMIT handshake with i=0, j>0, the block SHALL set j-=1 and stay in EMIT, with no memory read.
REQ-015 On EMIT handshake with j=0, i>0, the block SHALL set i-=1 and stay in EMIT, with no memory read.
REQ-016 On any other EMIT handshake, the block SHALL go to READ.
REQ-017 READ SHALL assert mem_rd_en=1 for exactly one cycle with mem_raddr={i,j}, then go to WAIT.
REQ-018 WAIT SHALL sample mem_rdata, apply the REQ-008 move to (i,j) and return to EMIT.
REQ-019 Throughput with out_ready held high SHALL be 3 cycles per interior point and 1 cycle per edge point.
REQ-020 DONE SHALL pulse done=1 for one cycle, then go to IDLE; start during DONE SHALL be ignored.
REQ-021 mem_rd_en SHALL be 0 in every state except READ; mem_raddr SHALL hold its last value otherwise.
REQ-022 Coordinates SHALL never decrement below 0; no wrap-around is permitted.
REQ-023 start asserted in any state other than IDLE SHALL have no effect.

Reset
REQ-024 nrst low SHALL immediately force IDLE, clear i and j to 0 and drive every output to 0, including mid-walk.
REQ-025 After nrst deasserts, the first start SHALL produce a complete, clean walk.

Configuration
REQ-026 DTW_TB_CHECK_EN defined: mem_rdata=00 in WAIT SHALL go to ERR, where error=1 and out_valid=0 until the next accepted start; ERR SHALL accept start as IDLE does.
REQ-027 DTW_TB_CHECK_EN undefined: code 00 SHALL be treated as 11 (diagonal), ERR SHALL be unreachable and error SHALL be tied to 0.

Structure
REQ-028 Shared package dtw_pkg SHALL hold the PATH0/PATH1/PATH2/PATH_RST codes, IDX_W=5, ADDR_W=10 and the traceback state enum; the PE array writes codes using the same constants.
REQ-029 A combinational sub-module dtw_tb_step SHALL compute the next (i,j) from the current (i,j) and a path code, including the edge overrides.

Verification
REQ-030 len_t=0, len_r=0, start -> one beat (0,0) with out_last=1 -> done pulse the cycle after the handshake; zero mem_rd_en.
REQ-031 len=2/2, RAM all 11 -> beats (2,2),(1,1),(0,0); reads at 0x042 and 0x021; out_last only on the third beat; 7 cycles from start to done with out_ready=1.
REQ-032 len_t=3, len_r=0 -> beats (3,0),(2,0),(1,0),(0,0) on consecutive cycles; no memory reads.
REQ-033 len=2/2, out_ready low for 5 cycles on the first beat -> out_valid/out_i/out_j stable and mem_rd_en=0 throughout; the walk then completes normally.
REQ-034 Code 00 at {2,2} -> with DTW_TB_CHECK_EN: error=1, no further beats, done never pulses; without: next beat is (1,1).
REQ-035 nrst pulsed low during WAIT -> all outputs 0 asynchronously; the subsequent start with len=1/1 yields (1,1),(0,0).

Source files
------------

// File: rtl/dtw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtw_pkg
// Purpose  : Path codes, index widths and traceback states shared by the DTW
//            PE array and the traceback walker.
// Revision : 1.0 - initial release
// ============================================================================
package dtw_pkg;

  localparam int IDX_W  = 5;
  localparam int ADDR_W = 2 * IDX_W;

  // Predecessor codes written by the PE array, one per cell.
  localparam logic [1:0] PATH0    = 2'b11;  // from (i-1, j-1)
  localparam logic [1:0] PATH1    = 2'b10;  // from (i-1, j)
  localparam logic [1:0] PATH2    = 2'b01;  // from (i, j-1)
  localparam logic [1:0] PATH_RST = 2'b00;  // cell never written

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EMIT = 3'd1;
  localparam logic [2:0] ST_READ = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  typedef enum logic [2:0] {
    TB_IDLE = ST_IDLE,
    TB_EMIT = ST_EMIT,
    TB_READ = ST_READ,
    TB_WAIT = ST_WAIT,
    TB_DONE = ST_DONE,
    TB_ERR  = ST_ERR
  } tb_state_e;

  function automatic logic [ADDR_W-1:0] tb_addr(input logic [IDX_W-1:0] i,
                                                input logic [IDX_W-1:0] j);
    return {i, j};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtw_tb_step.sv
`default_nettype none
// ============================================================================
// Module   : dtw_tb_step
// Purpose  : Combinational next-coordinate for one traceback move, with the
//            matrix-edge overrides taking priority over the stored path code.
// Revision : 1.0 - initial release
// ============================================================================
module dtw_tb_step
  import dtw_pkg::*;
(
  input  logic [IDX_W-1:0] i_i,
  input  logic [IDX_W-1:0] i_j,
  input  logic [1:0]       i_code,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j
);

  logic w_i_zero;
  logic w_j_zero;

  assign w_i_zero = (i_i == '0);
  assign w_j_zero = (i_j == '0);

  always_comb begin
    o_i = i_i;
    o_j = i_j;
    if (w_i_zero && w_j_zero) begin
      o_i = i_i;
      o_j = i_j;
    end else if (w_i_zero) begin
      o_j = i_j - 1'b1;
    end else if (w_j_zero) begin
      o_i = i_i - 1'b1;
    end else begin
      // An unwritten cell falls back to the diagonal move.
      case (i_code)
        PATH1: o_i = i_i - 1'b1;
        PATH2: o_j = i_j - 1'b1;
        default: begin
          o_i = i_i - 1'b1;
          o_j = i_j - 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtw_traceback.sv
`default_nettype none
// ============================================================================
// Module   : dtw_traceback
// Purpose  : Walks the DTW path-code RAM from (len_t,len_r) back to (0,0),
//            streaming one beat per visited cell. DTW_TB_CHECK_EN enables
//            trapping of unwritten (00) codes into an error state.
// Revision : 1.0 - initial release
// ============================================================================
module dtw_traceback
  import dtw_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [IDX_W-1:0]  len_t,
  input  logic [IDX_W-1:0]  len_r,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [1:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_i,
  output logic [IDX_W-1:0]  out_j,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
);

  tb_state_e         r_state;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic [ADDR_W-1:0] r_raddr;

  logic [IDX_W-1:0]  w_next_i;
  logic [IDX_W-1:0]  w_next_j;
  logic              w_at_origin;
  logic              w_on_edge;
  logic              w_emit;
  logic              w_bad_code;

  dtw_tb_step u_step (
    .i_i    (r_i),
    .i_j    (r_j),
    .i_code (mem_rdata),
    .o_i    (w_next_i),
    .o_j    (w_next_j)
  );

  assign w_at_origin = (r_i == '0) && (r_j == '0);
  assign w_on_edge   = (r_i == '0) || (r_j == '0);
  assign w_emit      = (r_state == TB_EMIT);

`ifdef DTW_TB_CHECK_EN
  assign w_bad_code = (mem_rdata == PATH_RST);
  assign error      = (r_state == TB_ERR);
`else
  assign w_bad_code = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= TB_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_raddr <= '0;
    end else begin
      case (r_state)
        TB_IDLE, TB_ERR: begin
          if (start) begin
            r_i     <= len_t;
            r_j     <= len_r;
            r_state <= TB_EMIT;
          end
        end
        TB_EMIT: begin
          if (out_ready) begin
            if (w_at_origin) begin
              r_state <= TB_DONE;
            end else if (w_on_edge) begin
              // Edge cells have only one predecessor; no RAM lookup needed.
              r_i <= w_next_i;
              r_j <= w_next_j;
            end else begin
              r_raddr <= tb_addr(r_i, r_j);
              r_state <= TB_READ;
            end
          end
        end
        TB_READ: r_state <= TB_WAIT;
        TB_WAIT: begin
          if (w_bad_code) begin
            r_state <= TB_ERR;
          end else begin
            r_i     <= w_next_i;
            r_j     <= w_next_j;
            r_state <= TB_EMIT;
          end
        end
        TB_DONE: r_state <= TB_IDLE;
        default: r_state <= TB_IDLE;
      endcase
    end
  end

  assign out_valid = w_emit;
  assign out_i     = w_emit ? r_i : '0;
  assign out_j     = w_emit ? r_j : '0;
  assign out_last  = w_emit && w_at_origin;
  assign busy      = (r_state != TB_IDLE);
  assign done      = (r_state == TB_DONE);
  assign mem_rd_en = (r_state == TB_READ);
  assign mem_raddr = r_raddr;

endmodule
`default_nettype wire

// File: tb/tb_dtw_traceback.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtw_traceback
// Purpose  : Scoreboard bench for dtw_traceback with a registered RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtw_traceback;
  import dtw_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic [4:0] len_t = '0;
  logic [4:0] len_r = '0;
  logic [1:0] mem_rdata = '0;
  logic       mem_rd_en;
  logic [9:0] mem_raddr;
  logic       out_valid;
  logic [4:0] out_i;
  logic [4:0] out_j;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       error;

  typedef struct {
    logic [4:0] i;
    logic [4:0] j;
    logic       last;
  } beat_t;

  logic [1:0] ram [0:1023];
  beat_t      exp_q[$];
  logic [9:0] addr_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         exp_lat;
  bit         exp_err;

  dtw_traceback dut (
    .clk(clk), .nrst(nrst), .start(start), .len_t(len_t), .len_r(len_r),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_j(out_j),
    .out_last(out_last), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_raddr];

  // Scoreboard monitor: beats and RAM reads are checked as they appear.
  always @(negedge clk) begin
    beat_t e;
    logic [9:0] a;
    if (nrst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got (%0d,%0d,last=%0d) expected none", out_i, out_j, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_i, out_j, out_last} !== {e.i, e.j, e.last}) begin
            errors++;
            $display("FAIL beat got (%0d,%0d,last=%0d) expected (%0d,%0d,last=%0d)",
                     out_i, out_j, out_last, e.i, e.j, e.last);
          end
        end
      end
      if (mem_rd_en) begin
        rd_cnt++;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got addr 0x%03h expected no read", mem_raddr);
        end else begin
          a = addr_q.pop_front();
          if (mem_raddr !== a) begin
            errors++;
            $display("FAIL read_addr got 0x%03h expected 0x%03h", mem_raddr, a);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_ram(input logic [1:0] code);
    for (int a = 0; a < 1024; a++) ram[a] = code;
  endtask

  // Reference walk: queues expected beats/reads and the start-to-done edge count.
  task automatic model_walk(input int lt, input int lr);
    int i;
    int j;
    beat_t b;
    logic [1:0] c;
    i = lt;
    j = lr;
    exp_lat = 0;
    exp_err = 0;
    while (1) begin
      b.i = 5'(i);
      b.j = 5'(j);
      b.last = (i == 0 && j == 0);
      exp_q.push_back(b);
      if (i == 0 && j == 0) begin
        exp_lat += 1;
        break;
      end
      if (i == 0) begin
        j--;
        exp_lat += 1;
      end else if (j == 0) begin
        i--;
        exp_lat += 1;
      end else begin
        addr_q.push_back({5'(i), 5'(j)});
        exp_lat += 3;
        c = ram[{5'(i), 5'(j)}];
`ifdef DTW_TB_CHECK_EN
        if (c == 2'b00) begin
          exp_err = 1;
          break;
        end
`endif
        if (c == 2'b10) i--;
        else if (c == 2'b01) j--;
        else begin
          i--;
          j--;
        end
      end
    end
  endtask

  task automatic do_start(input int lt, input int lr);
    @(posedge clk);
    #1;
    len_t = 5'(lt);
    len_r = 5'(lr);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok = 0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n - 1;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, busy, done, error, mem_rd_en, mem_raddr, out_i, out_j, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0d b=%0d d=%0d e=%0d rd=%0d expected all 0",
               out_valid, busy, done, error, mem_rd_en);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %0d expected 0", busy);
    end
  endtask

  task automatic test_single();
    int lat;
    bit ok;
    int rd0;
    fill_ram(2'b11);
    model_walk(0, 0);
    rd0 = rd_cnt;
    do_start(0, 0);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != exp_lat) begin
      errors++;
      $display("FAIL single_latency got %0d expected %0d", lat, exp_lat);
    end
    checks++;
    if (exp_q.size() != 0 || rd_cnt != rd0) begin
      errors++;
      $display("FAIL single_beats left %0d reads %0d expected 0 0", exp_q.size(), rd_cnt - rd0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%0d busy=%0d expected 0 0", done, busy);
    end
  endtask

  task automatic test_diag();
    int lat;
    bit ok;
    int rd0;
    fill_ram(2'b11);
    model_walk(2, 2);
    rd0 = rd_cnt;
    do_start(2, 2);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 7) begin
      errors++;
      $display("FAIL diag_latency got %0d expected 7", lat);
    end
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0 || rd_cnt - rd0 != 2) begin
      errors++;
      $display("FAIL diag_walk left %0d/%0d reads %0d expected 0/0 2",
               exp_q.size(), addr_q.size(), rd_cnt - rd0);
    end
  endtask

  task automatic test_edge();
    int lat;
    bit ok;
    int rd0;
    int lts[2] = '{3, 0};
    int lrs[2] = '{0, 3};
    for (int k = 0; k < 2; k++) begin
      model_walk(lts[k], lrs[k]);
      rd0 = rd_cnt;
      do_start(lts[k], lrs[k]);
      wait_done(lat, ok);
      checks++;
      if (!ok || lat != 4) begin
        errors++;
        $display("FAIL edge_latency got %0d expected 4", lat);
      end
      checks++;
      if (exp_q.size() != 0 || rd_cnt != rd0) begin
        errors++;
        $display("FAIL edge_walk left %0d reads %0d expected 0 0", exp_q.size(), rd_cnt - rd0);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    bit ok;
    fill_ram(2'b11);
    model_walk(2, 2);
    out_ready = 1'b0;
    do_start(2, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_i !== 5'd2 || out_j !== 5'd2 || mem_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got v=%0d (%0d,%0d) rd=%0d expected 1 (2,2) 0",
                 out_valid, out_i, out_j, mem_rd_en);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(lat, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL stall_complete done=%0d left %0d expected 1 0", ok, exp_q.size());
    end
  endtask

  task automatic test_busy_start();
    int lat;
    bit ok;
    fill_ram(2'b11);
    model_walk(2, 2);
    do_start(2, 2);
    len_t = 5'd0;
    len_r = 5'd0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, ok);
    start = 1'b1;
    len_t = 5'd1;
    len_r = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start done=%0d left %0d busy=%0d expected 1 0 0", ok, exp_q.size(), busy);
    end
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    int lts[2] = '{5, 7};
    int lrs[2] = '{4, 9};
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) ram[a] = 2'($urandom_range(1, 3));
      model_walk(lts[k], lrs[k]);
      do_start(lts[k], lrs[k]);
      wait_done(lat, ok);
      checks++;
      if (!ok || lat != exp_lat || exp_q.size() != 0 || addr_q.size() != 0) begin
        errors++;
        $display("FAIL random_walk lat %0d expected %0d left %0d/%0d",
                 lat, exp_lat, exp_q.size(), addr_q.size());
      end
    end
  endtask

  task automatic test_invalid();
    int lat;
    bit ok;
    int d0;
    fill_ram(2'b11);
    ram[{5'd2, 5'd2}] = 2'b00;
    model_walk(2, 2);
    d0 = done_cnt;
    do_start(2, 2);
`ifdef DTW_TB_CHECK_EN
    repeat (20) @(negedge clk);
    checks++;
    if (error !== 1'b1 || out_valid !== 1'b0 || done_cnt != d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_trap err=%0d v=%0d dones=%0d left %0d expected 1 0 0 0",
               error, out_valid, done_cnt - d0, exp_q.size());
    end
    fill_ram(2'b11);
    model_walk(0, 0);
    do_start(0, 0);
    wait_done(lat, ok);
    checks++;
    if (!ok || error !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL invalid_recover done=%0d err=%0d expected 1 0", ok, error);
    end
`else
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 7 || exp_q.size() != 0 || error !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL invalid_diag lat %0d expected 7 left %0d err=%0d", lat, exp_q.size(), error);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    bit seen;
    fill_ram(2'b11);
    model_walk(2, 2);
    do_start(2, 2);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_read got no read expected one");
    end
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, error, mem_rd_en, mem_raddr, out_i, out_j, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got v=%0d b=%0d rd=%0d addr=0x%03h expected all 0",
               out_valid, busy, mem_rd_en, mem_raddr);
    end
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_walk(1, 1);
    do_start(1, 1);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 4 || exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_walk lat %0d expected 4 left %0d", lat, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_diag();
    test_edge();
    test_stall();
    test_busy_start();
    test_random();
    test_invalid();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
